// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared types and constants for the 8-way mux round-robin scheduler and its picker.
package mux_sched_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return N_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/mux8_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N_REQ.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] winner
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] idx;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) idx = SEL_W'(i);
        end
        any    = |req;
        winner = idx + ptr;
    end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner of the shared 8:1 mux select; registered select/grant with a dead cycle between owners.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | no owner; sel_valid=0, busy=0, waiting for any request
//  ST_GRANT | owner holds sel/gnt stable; sel_valid=1, busy=1
//  ST_GAP   | single dead cycle after an owner; sel held, gnt=0, busy=1
module mux8_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             sel_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             sel_valid_q, sel_valid_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_winner;
    logic             hold_expired;
    logic             grant_exit;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    assign grant_exit   = done || !req[sel_q] || hold_expired;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_GAP: begin
                if (pick_any) begin
                    state_d     = ST_GRANT;
                    sel_d       = pick_winner;
                    gnt_d       = sel_onehot(pick_winner);
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            ST_GRANT: begin
                // Saturate so a long unlimited burst can never wrap into a fake hold expiry.
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                if (grant_exit) begin
                    state_d     = ST_GAP;
                    ptr_d       = sel_q + SEL_W'(1);
                    gnt_d       = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                sel_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            gnt_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Scoreboard bench: directed stimulus queues expected owners, a negedge monitor checks each valid cycle.
module tb_mux8_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       sel_valid;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    mux8_rr_scheduler #(.MAX_HOLD(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .gnt       (gnt),
        .sel_valid (sel_valid),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [2:0] s, input logic [7:0] g,
                             input logic v, input logic b);
        chk({name, "_sel"}, 32'(sel), 32'(s));
        chk({name, "_gnt"}, 32'(gnt), 32'(g));
        chk({name, "_valid"}, 32'(sel_valid), 32'(v));
        chk({name, "_busy"}, 32'(busy), 32'(b));
    endtask

    task automatic cyc(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #2;
        check_out("reset", 3'd0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every valid cycle consumes one queued owner; outside GRANT the grant must be zero.
    always @(negedge clk) begin
        logic [2:0] e;
        logic [7:0] g_exp;
        if (rst_n === 1'b1) begin
            if (sel_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual sel=%0d required=no valid cycle", sel);
                end else begin
                    e     = exp_q.pop_front();
                    g_exp = 8'h01 << e;
                    chk("mon_sel", 32'(sel), 32'(e));
                    chk("mon_gnt", 32'(gnt), 32'(g_exp));
                    chk("mon_busy", 32'(busy), 32'd1);
                end
            end else begin
                chk("mon_nogrant_gnt", 32'(gnt), 32'd0);
            end
        end
    end

    initial begin
        // 1: single request, one-cycle latency, then done
        do_reset();
        exp_q.push_back(3'd0);
        cyc(8'h01, 1'b0);
        check_out("t1_grant", 3'd0, 8'h01, 1'b1, 1'b1);
        cyc(8'h01, 1'b1);
        check_out("t1_gap", 3'd0, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0);
        check_out("t1_idle", 3'd0, 8'h00, 1'b0, 1'b0);

        // 2: all requesting, done on the 2nd GRANT cycle -> 0..7,0 with 2 valid cycles each
        do_reset();
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(3'(i % 8));
            exp_q.push_back(3'(i % 8));
        end
        cyc(8'hFF, 1'b0);
        check_out("t2_first", 3'd0, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc(8'hFF, 1'b0);
            cyc(8'hFF, 1'b1);
            check_out("t2_gap", 3'(i % 8), 8'h00, 1'b0, 1'b1);
            if (i < 8) cyc(8'hFF, 1'b0);
        end
        cyc(8'h00, 1'b0);
        check_out("t2_idle", 3'd0, 8'h00, 1'b0, 1'b0);

        // 3: hold limit of 4 cycles with req=0x05 and no done
        do_reset();
        repeat (4) exp_q.push_back(3'd0);
        repeat (4) exp_q.push_back(3'd2);
        exp_q.push_back(3'd0);
        cyc(8'h05, 1'b0);
        repeat (4) cyc(8'h05, 1'b0);
        check_out("t3_gap0", 3'd0, 8'h00, 1'b0, 1'b1);
        cyc(8'h05, 1'b0);
        check_out("t3_grant2", 3'd2, 8'h04, 1'b1, 1'b1);
        repeat (4) cyc(8'h05, 1'b0);
        check_out("t3_gap2", 3'd2, 8'h00, 1'b0, 1'b1);
        cyc(8'h05, 1'b0);
        check_out("t3_grant0", 3'd0, 8'h01, 1'b1, 1'b1);
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b0);
        check_out("t3_idle", 3'd0, 8'h00, 1'b0, 1'b0);

        // 4: owner 3 drops its request on GRANT cycle 2
        do_reset();
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        cyc(8'h08, 1'b0);
        cyc(8'h08, 1'b0);
        cyc(8'h00, 1'b0);
        check_out("t4_gap", 3'd3, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_valid", 32'(sel_valid), 32'd0);

        // 5: pointer wrap, grant 6 done then req=0x41 searches 7,0
        do_reset();
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd0);
        cyc(8'h40, 1'b0);
        cyc(8'h40, 1'b1);
        check_out("t5_gap", 3'd6, 8'h00, 1'b0, 1'b1);
        cyc(8'h41, 1'b0);
        check_out("t5_wrap", 3'd0, 8'h01, 1'b1, 1'b1);
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b0);
        check_out("t5_idle", 3'd0, 8'h00, 1'b0, 1'b0);

        // 6: async reset mid-GRANT, then release with req=0x80
        do_reset();
        cyc(8'h10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t6_async", 3'd0, 8'h00, 1'b0, 1'b0);
        req = 8'h80;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(3'd7);
        @(posedge clk);
        #1;
        check_out("t6_after", 3'd7, 8'h80, 1'b1, 1'b1);
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b0);
        check_out("t6_idle", 3'd7, 8'h00, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
